// File: rtl/cic_comp_fir.sv
// Decimating CIC-droop compensation FIR: one time-shared MAC, round/saturate to 16 bits.
// out_tick NTAPS+2 cycles after the triggering tick; in_tick while the MAC is busy is dropped and flags overrun.
module cic_comp_fir #(
  parameter int NTAPS     = 32,
  parameter int DECIM     = 2,
  parameter int COEF_BITS = 16
) (
  input  logic                        CLK,
  input  logic                        RSTb,
  input  logic signed [15:0]          x_in,
  input  logic                        in_tick,
  input  logic                        coef_we,
  input  logic [$clog2(NTAPS)-1:0]    coef_addr,
  input  logic signed [COEF_BITS-1:0] coef_data,
  output logic signed [15:0]          y_out,
  output logic                        out_tick,
  output logic                        busy,
  output logic                        overrun
);

  localparam int AW   = $clog2(NTAPS);
  localparam int PW   = 16 + COEF_BITS;
  localparam int ACCW = PW + AW;
  localparam int PHW  = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [PHW-1:0]         PH_LAST = PHW'(DECIM - 1);
  localparam logic [AW-1:0]          K_LAST  = AW'(NTAPS - 1);
  localparam logic signed [ACCW-1:0] RND     = {{(ACCW-1){1'b0}}, 1'b1} << (COEF_BITS - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic signed [15:0]          buf_q  [NTAPS];
  logic signed [COEF_BITS-1:0] coef_q [NTAPS];

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          base_q, base_d;
  logic [AW-1:0]          k_q, k_d;
  logic [PHW-1:0]         ph_q, ph_d;
  logic                   trig_q, trig_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  logic                   pvld_q, pvld_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [15:0]     y_q, y_d;
  logic                   otick_q, otick_d;
  logic                   ovr_q, ovr_d;

  logic                   lock;
  logic                   accept;
  logic [AW-1:0]          rd_idx;
  logic signed [PW-1:0]   prod_w;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] sum_w;
  logic signed [ACCW-1:0] rnd_w;
  logic signed [ACCW-1:0] shf_w;
  logic [ACCW-16:0]       hi_w;
  logic signed [15:0]     y_sat;

  // A pending trigger already counts as busy so no sample can slip in between trigger and MAC start.
  assign lock   = trig_q | (state_q == S_MAC) | (state_q == S_FLUSH);
  assign accept = in_tick & ~lock;

  assign rd_idx   = base_q - k_q;
  assign prod_w   = coef_q[k_q] * buf_q[rd_idx];
  assign prod_ext = $signed({{AW{prod_q[PW-1]}}, prod_q});
  assign sum_w    = acc_q + prod_ext;
  assign rnd_w    = sum_w + RND;
  assign shf_w    = rnd_w >>> (COEF_BITS - 1);
  assign hi_w     = shf_w[ACCW-1:15];

  always_comb begin
    y_sat = shf_w[15:0];
    if (!((&hi_w) || (~|hi_w))) begin
      y_sat = shf_w[ACCW-1] ? 16'sh8000 : 16'sh7fff;
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    base_d  = base_q;
    k_d     = k_q;
    ph_d    = ph_q;
    trig_d  = 1'b0;
    prod_d  = prod_q;
    pvld_d  = pvld_q;
    acc_d   = acc_q;
    y_d     = y_q;
    otick_d = 1'b0;
    ovr_d   = ovr_q;

    if (accept) begin
      wptr_d = wptr_q + AW'(1);
      if (ph_q == PH_LAST) begin
        ph_d   = '0;
        trig_d = 1'b1;
        base_d = wptr_q;
      end else begin
        ph_d = ph_q + PHW'(1);
      end
    end
    if (in_tick && lock) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trig_q) begin
          state_d = S_MAC;
          acc_d   = '0;
          k_d     = '0;
          pvld_d  = 1'b0;
        end
      end
      S_MAC: begin
        prod_d = prod_w;
        pvld_d = 1'b1;
        if (pvld_q) begin
          acc_d = sum_w;
        end
        k_d = k_q + AW'(1);
        if (k_q == K_LAST) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Final product is folded in combinationally, so the result lands with the out_tick.
        y_d     = y_sat;
        otick_d = 1'b1;
        pvld_d  = 1'b0;
        state_d = S_OUT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      base_q  <= '0;
      k_q     <= '0;
      ph_q    <= '0;
      trig_q  <= 1'b0;
      prod_q  <= '0;
      pvld_q  <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
      otick_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        buf_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      base_q  <= base_d;
      k_q     <= k_d;
      ph_q    <= ph_d;
      trig_q  <= trig_d;
      prod_q  <= prod_d;
      pvld_q  <= pvld_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      otick_q <= otick_d;
      ovr_q   <= ovr_d;
      if (accept) begin
        buf_q[wptr_q] <= x_in;
      end
      if (coef_we && (state_q == S_IDLE)) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

  assign y_out    = y_q;
  assign out_tick = otick_q;
  assign busy     = (state_q != S_IDLE);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: directed test-plan steps plus random samples/coefficients
// compared against a sample-history convolution model.
module tb_cic_comp_fir;

  localparam int NTAPS = 32;
  localparam int CB    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstb;
  logic signed [15:0] x_in;
  logic               in_tick;
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               sel;

  logic               it1, it2, we1, we2;
  logic signed [15:0] y1, y2;
  logic               ot1, ot2, b1, b2, ov1, ov2;
  logic signed [15:0] y_s;
  logic               ot_s, b_s, ov_s;

  assign it1  = in_tick & ~sel;
  assign it2  = in_tick & sel;
  assign we1  = coef_we & ~sel;
  assign we2  = coef_we & sel;
  assign y_s  = sel ? y2 : y1;
  assign ot_s = sel ? ot2 : ot1;
  assign b_s  = sel ? b2 : b1;
  assign ov_s = sel ? ov2 : ov1;

  cic_comp_fir #(.NTAPS(NTAPS), .DECIM(1), .COEF_BITS(CB)) u_d1 (
    .CLK(clk), .RSTb(rstb), .x_in(x_in), .in_tick(it1), .coef_we(we1),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y1), .out_tick(ot1), .busy(b1), .overrun(ov1)
  );

  cic_comp_fir #(.NTAPS(NTAPS), .DECIM(2), .COEF_BITS(CB)) u_d2 (
    .CLK(clk), .RSTb(rstb), .x_in(x_in), .in_tick(it2), .coef_we(we2),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y2), .out_tick(ot2), .busy(b2), .overrun(ov2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: coefficients, newest-first history of accepted samples, decimation phase.
  int                 coef_m [NTAPS];
  int                 hist[$];
  int                 ph_m;
  int                 decim_m;
  longint             last_y;
  logic signed [15:0] y_obs;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  function automatic longint model_y();
    longint s = 0;
    longint r;
    for (int k = 0; k < hist.size(); k++) s += longint'(coef_m[k]) * longint'(hist[k]);
    r = (s + 16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) coef_m[k] = 0;
    hist.delete();
    ph_m   = 0;
    last_y = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_coef(input int k, input int v);
    coef_we   = 1'b1;
    coef_addr = 5'(k);
    coef_data = 16'(v);
    @(posedge clk);
    #1;
    coef_we   = 1'b0;
    coef_m[k] = int'(coef_data);
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < NTAPS; k++) set_coef(k, v);
  endtask

  task automatic pulse_reset();
    rstb = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    model_reset();
  endtask

  // One accepted tick at edge T, then watch edges T+1..T+NTAPS+3; stray=1 also injects
  // ticks and a coefficient write inside the busy window, all of which must be ignored.
  task automatic send(input int val, input bit stray);
    bit                 trig;
    longint             e;
    int                 fired;
    int                 at;
    logic signed [15:0] ycap;
    x_in    = 16'(val);
    in_tick = 1'b1;
    @(posedge clk);
    #1;
    in_tick = 1'b0;
    hist.push_front(int'(x_in));
    if (hist.size() > NTAPS) void'(hist.pop_back());
    trig  = (ph_m == decim_m - 1);
    ph_m  = trig ? 0 : ph_m + 1;
    e     = model_y();
    fired = 0;
    at    = 0;
    ycap  = '0;
    for (int j = 1; j <= NTAPS + 3; j++) begin
      if (stray && (j == 1 || j % 10 == 0 || j == NTAPS + 2)) begin
        in_tick = 1'b1;
        x_in    = 16'($urandom);
      end
      if (stray && j == 15) begin
        coef_we   = 1'b1;
        coef_addr = 5'd0;
        coef_data = 16'($urandom);
      end
      @(posedge clk);
      #1;
      in_tick = 1'b0;
      coef_we = 1'b0;
      if (ot_s === 1'b1) begin
        fired++;
        at   = j;
        ycap = y_s;
      end
      if (j == 1) chk("busy_rise", b_s, trig);
    end
    chk("busy_fall", b_s, 0);
    chk("out_tick_count", fired, trig);
    if (trig) begin
      chk("out_latency", at, NTAPS + 2);
      chk("y_out", ycap, e);
      last_y = e;
      y_obs  = ycap;
    end
    chk("y_held", y_s, last_y);
    if (stray) chk("overrun_set", ov_s, 1);
  endtask

  initial begin
    int fired;
    rstb      = 1'b0;
    x_in      = '0;
    in_tick   = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    sel       = 1'b0;
    decim_m   = 1;
    y_obs     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    idle(1);

    // Reset state on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_y", y_s, 0);
      chk("rst_out_tick", ot_s, 0);
      chk("rst_busy", b_s, 0);
      chk("rst_overrun", ov_s, 0);
    end
    sel = 1'b0;

    // Passthrough
    set_coef(0, 'h7fff);
    send(1000, 0);   chk("pass_1000", y_obs, 1000);   idle(25);
    send(-1000, 0);  chk("pass_m1000", y_obs, -1000); idle(25);
    send(32767, 0);  chk("pass_32767", y_obs, 32766);

    // Impulse through all-0x4000 taps
    pulse_reset();
    set_all('h4000);
    send('h2000, 0);
    chk("impulse_first", y_obs, 'h1000);
    for (int i = 0; i < NTAPS; i++) send(0, 0);
    chk("impulse_tail", y_obs, 0);

    // Saturation both ways
    set_all('h7fff);
    for (int i = 0; i < 40; i++) send('h7fff, 0);
    chk("sat_pos", y_obs, 32767);
    for (int i = 0; i < 40; i++) send('h8000, 0);
    chk("sat_neg", y_obs, -32768);

    // Random coefficients and samples
    pulse_reset();
    for (int k = 0; k < NTAPS; k++) set_coef(k, int'($urandom_range(65535, 0)));
    for (int i = 0; i < 24; i++) send(int'($urandom_range(65535, 0)), 0);

    // Overrun and coefficient lock
    pulse_reset();
    set_coef(0, 'h4000);
    set_coef(1, 'h4000);
    chk("ovr_clear", ov_s, 0);
    send(1000, 1);
    chk("ovr_first", y_obs, 500);
    send(600, 0);
    chk("ovr_after", y_obs, 800);
    chk("ovr_sticky", ov_s, 1);

    // Reset in the middle of a MAC
    x_in    = 16'sd5000;
    in_tick = 1'b1;
    @(posedge clk);
    #1;
    in_tick = 1'b0;
    idle(4);
    pulse_reset();
    fired = 0;
    for (int j = 0; j < NTAPS + 4; j++) begin
      @(posedge clk);
      #1;
      if (ot_s === 1'b1) fired++;
    end
    chk("midrst_no_tick", fired, 0);
    chk("midrst_y", y_s, 0);
    chk("midrst_busy", b_s, 0);
    chk("midrst_overrun", ov_s, 0);
    y_obs = 16'sd1;
    send(3000, 0);
    chk("midrst_zero_coef", y_obs, 0);

    // Decimation by two on the second instance (untouched since the last reset)
    sel     = 1'b1;
    decim_m = 2;
    model_reset();
    set_coef(0, 'h7fff);
    send(1, 0);
    send(2, 0);  chk("decim_2", y_obs, 2);
    send(3, 0);
    send(4, 0);  chk("decim_4", y_obs, 4);
    for (int k = 0; k < NTAPS; k++) set_coef(k, int'($urandom_range(65535, 0)));
    for (int i = 0; i < 12; i++) send(int'($urandom_range(65535, 0)), 0);
    chk("decim_overrun", ov_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
